// File: rtl/alg_pkg.sv
// Shared types and default widths for the ECG algorithm blocks.
package alg_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int CTR_WIDTH  = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRACK   = 3'd1,
    ARMED   = 3'd2,
    SEARCH  = 3'd3,
    REPORT  = 3'd4,
    REFRACT = 3'd5
  } qrs_search_state_t;

  // Larger of two ints, used when sizing window counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/peak_tracker.sv
// Running-maximum register with an optional location tag.
// load overwrites unconditionally; cmp overwrites only on a strictly larger
// sample so the earliest of several equal peaks keeps its location.
module peak_tracker #(
  parameter int DATA_WIDTH = 11,
  parameter int CTR_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  cmp,
  input  logic                  with_ctr,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [CTR_WIDTH-1:0]  ctr,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [CTR_WIDTH-1:0]  peak_ctr
);

  logic greater;
  logic take;

  assign greater = (sample > max_val);
  assign take    = load | (cmp & greater);

  // Capture the sample (and optionally its index) when loaded or exceeded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val  <= '0;
      peak_ctr <= '0;
    end else if (take) begin
      max_val <= sample;
      if (with_ctr) peak_ctr <= ctr;
    end
  end

endmodule

// File: rtl/qrs_search.sv
// QRS peak search: tracks the abs-diff maximum, opens a fixed-length search
// window when the threshold is exceeded, reports the window's peak location
// with a one-cycle pulse, then ignores a refractory span of samples.
module qrs_search
  import alg_pkg::*;
#(
  parameter int DATA_WIDTH     = alg_pkg::DATA_WIDTH,
  parameter int CTR_WIDTH      = alg_pkg::CTR_WIDTH,
  parameter int SEARCH_LEN     = 20,
  parameter int REFRACTORY_LEN = 40
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_abs_diff,
  input  logic [CTR_WIDTH-1:0]  i_ctr,
  input  logic                  i_search_en,
  input  logic [DATA_WIDTH-1:0] i_threshold,
  output logic [DATA_WIDTH-1:0] o_abs_diff_short_max,
  output logic                  o_abs_diff_short_valid,
  output logic                  o_extremum_found,
  output logic [CTR_WIDTH-1:0]  o_extremum_ctr
);

  // Wide enough to hold either window length plus one, so it never wraps.
  localparam int CNT_W = $clog2(max_int(SEARCH_LEN, REFRACTORY_LEN) + 1);
  localparam logic [CNT_W-1:0] SEARCH_LAST  = CNT_W'(SEARCH_LEN - 1);
  localparam logic [CNT_W-1:0] REFRACT_LAST = CNT_W'(REFRACTORY_LEN - 1);

  qrs_search_state_t state, state_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              load, cmp, with_ctr;
  logic              valid;
  logic              found;
  logic              trigger;

  assign trigger = i_search_en & i_ce & (i_abs_diff > i_threshold);

  peak_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTR_WIDTH  (CTR_WIDTH)
  ) u_peak (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (load),
    .cmp      (cmp),
    .with_ctr (with_ctr),
    .sample   (i_abs_diff),
    .ctr      (i_ctr),
    .max_val  (o_abs_diff_short_max),
    .peak_ctr (o_extremum_ctr)
  );

  // State and window counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state, counter and tracker controls.
  always_comb begin
    state_next = state;
    count_next = count;
    load       = 1'b0;
    cmp        = 1'b0;
    with_ctr   = 1'b0;
    case (state)
      IDLE: begin
        if (i_ce) begin
          load       = 1'b1;
          state_next = TRACK;
        end
      end
      TRACK: begin
        cmp = i_ce;
        if (i_search_en) state_next = ARMED;
      end
      ARMED: begin
        if (!i_search_en) begin
          state_next = TRACK;
        end else if (trigger) begin
          load       = 1'b1;
          with_ctr   = 1'b1;
          count_next = CNT_W'(1);
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        // search_en is deliberately ignored so an open window always completes.
        if (i_ce) begin
          cmp        = 1'b1;
          with_ctr   = 1'b1;
          count_next = count + 1'b1;
          if (count == SEARCH_LAST) state_next = REPORT;
        end
      end
      REPORT: begin
        count_next = '0;
        state_next = REFRACT;
      end
      REFRACT: begin
        if (i_ce) begin
          count_next = count + 1'b1;
          if (count == REFRACT_LAST)
            state_next = i_search_en ? ARMED : TRACK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered report pulse, high exactly while the FSM sits in REPORT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) found <= 1'b0;
    else       found <= (state_next == REPORT);
  end

  // Valid latches on the first captured sample and stays until reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                        valid <= 1'b0;
    else if (state == IDLE && i_ce)   valid <= 1'b1;
  end

  assign o_extremum_found       = found;
  assign o_abs_diff_short_valid = valid;

endmodule
